// File: rtl/pico_mem_pkg.sv
// Shared constants for the PicoBlaze shared-memory arbiter: default port IDs,
// command codes and the bit layout of the status byte.
package pico_mem_pkg;
    localparam logic [7:0] DEF_P_ADDR  = 8'h40;
    localparam logic [7:0] DEF_P_DIN   = 8'h41;
    localparam logic [7:0] DEF_P_CMD   = 8'h42;
    localparam logic [7:0] DEF_P_STAT  = 8'h43;
    localparam logic [7:0] DEF_P_RDATA = 8'h44;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
endpackage

// File: rtl/pico_mem_req_port.sv
// One requester's view of the shared memory: address/data registers, the
// posted-request shadow, BUSY/DONE/ERR tracking and the KCPSM6 read mux.
module pico_mem_req_port
    import pico_mem_pkg::*;
#(
    parameter logic [7:0] P_ADDR  = DEF_P_ADDR,
    parameter logic [7:0] P_DIN   = DEF_P_DIN,
    parameter logic [7:0] P_CMD   = DEF_P_CMD,
    parameter logic [7:0] P_STAT  = DEF_P_STAT,
    parameter logic [7:0] P_RDATA = DEF_P_RDATA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_data,
    input  logic       grant,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       op_write,
    output logic [7:0] op_addr,
    output logic [7:0] op_data
);
    logic [7:0] addr_reg;
    logic [7:0] din_reg;
    logic [7:0] rdata_reg;
    logic       done;
    logic       err;
    logic [7:0] stat;

    logic cmd_wr;
    logic post;
    logic accept;
    logic reject;
    logic rd_rdata;
    logic rd_stat;

    assign cmd_wr   = write_strobe && (port_id == P_CMD);
    assign post     = cmd_wr && ((out_port == CMD_WRITE) || (out_port == CMD_READ));
    // A request completing on this edge frees the slot for a new posting.
    assign accept   = post && (!busy || grant);
    assign reject   = post && busy && !grant;
    assign rd_rdata = read_strobe && (port_id == P_RDATA);
    assign rd_stat  = read_strobe && (port_id == P_STAT);

    always_comb begin
        stat            = 8'h00;
        stat[STAT_BUSY] = busy;
        stat[STAT_DONE] = done;
        stat[STAT_ERR]  = err;
    end

    always_comb begin
        in_data = 8'h00;
        if (port_id == P_ADDR)       in_data = addr_reg;
        else if (port_id == P_DIN)   in_data = din_reg;
        else if (port_id == P_STAT)  in_data = stat;
        else if (port_id == P_RDATA) in_data = rdata_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg  <= 8'h00;
            din_reg   <= 8'h00;
            rdata_reg <= 8'h00;
            op_write  <= 1'b0;
            op_addr   <= 8'h00;
            op_data   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (write_strobe && (port_id == P_ADDR)) addr_reg <= out_port;
            if (write_strobe && (port_id == P_DIN))  din_reg  <= out_port;

            if (grant && !op_write) rdata_reg <= mem_rdata;

            if (accept) begin
                busy     <= 1'b1;
                op_write <= (out_port == CMD_WRITE);
                op_addr  <= addr_reg;
                op_data  <= din_reg;
            end else if (grant) begin
                busy <= 1'b0;
            end

            // Completion outranks a coincident DONE clear; new errors outrank an ERR clear.
            if (grant)         done <= 1'b1;
            else if (rd_rdata) done <= 1'b0;

            if (reject)       err <= 1'b1;
            else if (rd_stat) err <= 1'b0;
        end
    end
endmodule

// File: rtl/pico_shared_mem_arbiter.sv
// Two KCPSM6 requesters sharing one 256x8 register-array memory through a
// round-robin arbiter that grants a single access per clock edge.
module pico_shared_mem_arbiter
    import pico_mem_pkg::*;
#(
    parameter logic [7:0] P_ADDR  = DEF_P_ADDR,
    parameter logic [7:0] P_DIN   = DEF_P_DIN,
    parameter logic [7:0] P_CMD   = DEF_P_CMD,
    parameter logic [7:0] P_STAT  = DEF_P_STAT,
    parameter logic [7:0] P_RDATA = DEF_P_RDATA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pA_port_id,
    input  logic [7:0] pA_out_port,
    input  logic       pA_write_strobe,
    input  logic       pA_read_strobe,
    output logic [7:0] pA_in_data,
    input  logic [7:0] pB_port_id,
    input  logic [7:0] pB_out_port,
    input  logic       pB_write_strobe,
    input  logic       pB_read_strobe,
    output logic [7:0] pB_in_data
);
    logic [7:0] mem [0:255];

    logic       busy_a, busy_b;
    logic       write_a, write_b;
    logic [7:0] addr_a, addr_b;
    logic [7:0] data_a, data_b;
    logic       grant_a, grant_b;
    logic       ptr_b;

    // Pointer names the winner under contention and then hands priority to the loser.
    assign grant_a = busy_a && (!busy_b || !ptr_b);
    assign grant_b = busy_b && (!busy_a ||  ptr_b);

    always_ff @(posedge clk) begin
        if (reset)                ptr_b <= 1'b0;
        else if (busy_a && busy_b) ptr_b <= ~ptr_b;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (grant_a && write_a)      mem[addr_a] <= data_a;
            else if (grant_b && write_b) mem[addr_b] <= data_b;
        end
    end

    pico_mem_req_port #(
        .P_ADDR(P_ADDR), .P_DIN(P_DIN), .P_CMD(P_CMD), .P_STAT(P_STAT), .P_RDATA(P_RDATA)
    ) u_port_a (
        .clk          (clk),
        .reset        (reset),
        .port_id      (pA_port_id),
        .out_port     (pA_out_port),
        .write_strobe (pA_write_strobe),
        .read_strobe  (pA_read_strobe),
        .in_data      (pA_in_data),
        .grant        (grant_a),
        .mem_rdata    (mem[addr_a]),
        .busy         (busy_a),
        .op_write     (write_a),
        .op_addr      (addr_a),
        .op_data      (data_a)
    );

    pico_mem_req_port #(
        .P_ADDR(P_ADDR), .P_DIN(P_DIN), .P_CMD(P_CMD), .P_STAT(P_STAT), .P_RDATA(P_RDATA)
    ) u_port_b (
        .clk          (clk),
        .reset        (reset),
        .port_id      (pB_port_id),
        .out_port     (pB_out_port),
        .write_strobe (pB_write_strobe),
        .read_strobe  (pB_read_strobe),
        .in_data      (pB_in_data),
        .grant        (grant_b),
        .mem_rdata    (mem[addr_b]),
        .busy         (busy_b),
        .op_write     (write_b),
        .op_addr      (addr_b),
        .op_data      (data_b)
    );
endmodule
